// File: rtl/instr_fetch.sv
// Instruction-fetch stage.
// Holds the PC and issues one word request at a time to instruction memory over a
// req/ack handshake. Fetched words go to decode together with their PC. A one-entry
// skid buffer absorbs a response that arrives while decode is stalled. A redirect
// discards any in-flight wrong-path fetch.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem_req        request valid, held until imem_ack
//   imem_addr       address of the outstanding request, stable while imem_req=1
//   imem_ack        memory response valid (may come in the same cycle as the request)
//   imem_rdata      instruction word, valid with imem_ack
//   stall_in        decode cannot accept; instr_out/pc_out hold
//   redirect_valid  taken branch/jump: restart fetch at redirect_pc
//   redirect_pc     new PC, bits [1:0] ignored
//   instr_out       instruction to decode
//   pc_out          PC of instr_out
//   instr_valid     instr_out/pc_out valid; consumed on instr_valid & !stall_in
module instr_fetch #(
    parameter int unsigned         data_width = 32,
    parameter int unsigned         pc_width   = 32,
    parameter logic [pc_width-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [pc_width-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [data_width-1:0] imem_rdata,
    input  logic                  stall_in,
    input  logic                  redirect_valid,
    input  logic [pc_width-1:0]   redirect_pc,
    output logic [data_width-1:0] instr_out,
    output logic [pc_width-1:0]   pc_out,
    output logic                  instr_valid
);

    typedef enum logic [1:0] {StIdle, StReq, StSkid, StFlush} state_e;

    localparam logic [pc_width-1:0] PcStep = pc_width'(4);

    state_e                state_q, state_d;
    logic [pc_width-1:0]   pc_q, pc_d;
    logic [pc_width-1:0]   flush_addr_q, flush_addr_d;
    logic [data_width-1:0] instr_q, instr_d;
    logic [pc_width-1:0]   pc_out_q, pc_out_d;
    logic                  valid_q, valid_d;
    logic [data_width-1:0] skid_instr_q, skid_instr_d;
    logic [pc_width-1:0]   skid_pc_q, skid_pc_d;

    logic [pc_width-1:0]   redirect_aligned;
    logic [pc_width-1:0]   pc_inc;

    assign redirect_aligned = {redirect_pc[pc_width-1:2], 2'b00};
    assign pc_inc           = pc_q + PcStep;  // wraps modulo 2^pc_width

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_addr_d = flush_addr_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (redirect_valid) begin
                    pc_d    = redirect_aligned;
                    valid_d = 1'b0;
                    if (!imem_ack) begin
                        // Wrong-path request must still complete before refetching.
                        flush_addr_d = pc_q;
                        state_d      = StFlush;
                    end
                end else if (imem_ack && (!valid_q || !stall_in)) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_inc;
                end else if (imem_ack) begin
                    skid_instr_d = imem_rdata;
                    skid_pc_d    = pc_q;
                    pc_d         = pc_inc;
                    state_d      = StSkid;
                end else if (valid_q && !stall_in) begin
                    valid_d = 1'b0;
                end
            end
            StSkid: begin
                if (redirect_valid) begin
                    pc_d    = redirect_aligned;
                    valid_d = 1'b0;
                    state_d = StReq;
                end else if (!stall_in) begin
                    instr_d  = skid_instr_q;
                    pc_out_d = skid_pc_q;
                    state_d  = StReq;
                end
            end
            StFlush: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                end
                if (imem_ack) begin
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            flush_addr_q <= '0;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_addr_q <= flush_addr_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    always_comb begin
        imem_addr = '0;
        unique case (state_q)
            StReq:   imem_addr = pc_q;
            StFlush: imem_addr = flush_addr_q;
            default: imem_addr = '0;
        endcase
    end

    assign imem_req    = (state_q == StReq) || (state_q == StFlush);
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    int unsigned n_vec;
    int unsigned n_miss;

    // Memory model: returns address as data, acks after ack_delay waiting cycles.
    logic        ack_en;
    int unsigned ack_delay;
    int unsigned wait_cnt;

    instr_fetch #(
        .data_width(32),
        .pc_width  (32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall_in      (stall_in),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_ack   = imem_req && ack_en && (wait_cnt >= ack_delay);
    assign imem_rdata = imem_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else                             wait_cnt <= wait_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ack_en         = 1'b1;
        ack_delay      = 0;
        @(negedge clk);
        check_eq("rst_req",   {31'b0, imem_req},    32'h0);
        check_eq("rst_addr",  imem_addr,            32'h0);
        check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
        check_eq("rst_pcout", pc_out,               32'h0);
        check_eq("rst_instr", instr_out,            32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance from release until pc_out==4*n is presented (zero-wait memory).
    task automatic run_to(input int unsigned n);
        for (int k = 0; k < int'(n) + 2; k++) @(negedge clk);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // 1: zero-wait streaming
        do_reset();
        @(negedge clk);
        check_eq("t1_req",    {31'b0, imem_req},    32'h1);
        check_eq("t1_addr0",  imem_addr,            32'h0);
        check_eq("t1_valid0", {31'b0, instr_valid}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t1_valid", {31'b0, instr_valid}, 32'h1);
            check_eq("t1_pc",    pc_out,               32'(4 * i));
            check_eq("t1_instr", instr_out,            32'(4 * i));
        end

        // 2: three-cycle ack delay
        ack_delay = 3;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check_eq("t2_addr",  imem_addr,            32'(24 + 4 * r));
                check_eq("t2_req",   {31'b0, imem_req},    32'h1);
                check_eq("t2_idle",  {31'b0, instr_valid}, 32'h0);
            end
            @(negedge clk);
            check_eq("t2_valid", {31'b0, instr_valid}, 32'h1);
            check_eq("t2_pc",    pc_out,               32'(24 + 4 * r));
        end
        @(negedge clk);
        check_eq("t2_pulse", {31'b0, instr_valid}, 32'h0);

        // 3: stall with a response landing in the skid buffer
        do_reset();
        run_to(4);
        check_eq("t3_pre", pc_out, 32'h10);
        stall_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("t3_hold_pc", pc_out,               32'h10);
            check_eq("t3_hold_in", instr_out,            32'h10);
            check_eq("t3_hold_v",  {31'b0, instr_valid}, 32'h1);
            check_eq("t3_noreq",   {31'b0, imem_req},    32'h0);
        end
        stall_in = 1'b0;
        @(negedge clk);
        check_eq("t3_skid_pc", pc_out,               32'h14);
        check_eq("t3_skid_in", instr_out,            32'h14);
        check_eq("t3_skid_v",  {31'b0, instr_valid}, 32'h1);
        check_eq("t3_resume",  imem_addr,            32'h18);
        @(negedge clk);
        check_eq("t3_next_pc", pc_out,               32'h18);

        // 4: redirect while a request is pending
        do_reset();
        run_to(7);
        check_eq("t4_pre", imem_addr, 32'h20);
        ack_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("t4_flush_a", imem_addr,            32'h20);
        check_eq("t4_flush_r", {31'b0, imem_req},    32'h1);
        check_eq("t4_flush_v", {31'b0, instr_valid}, 32'h0);
        @(negedge clk);
        check_eq("t4_flush_a2", imem_addr, 32'h20);
        ack_en = 1'b1;
        @(negedge clk);
        check_eq("t4_drop_v", {31'b0, instr_valid}, 32'h0);
        check_eq("t4_newaddr", imem_addr,           32'h100);
        @(negedge clk);
        check_eq("t4_first_v", {31'b0, instr_valid}, 32'h1);
        check_eq("t4_first_pc", pc_out,              32'h100);

        // 5: unaligned redirect with same-cycle ack
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("t5_drop_v", {31'b0, instr_valid}, 32'h0);
        check_eq("t5_addr",   imem_addr,            32'h200);
        @(negedge clk);
        check_eq("t5_pc",     pc_out,               32'h200);

        // 6: PC wrap, then reset in the middle of a request
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_eq("t6_top", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check_eq("t6_top_pc", pc_out,    32'hFFFF_FFFC);
        check_eq("t6_wrap",   imem_addr, 32'h0);
        @(negedge clk);
        check_eq("t6_wrap_pc", pc_out, 32'h0);
        ack_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_req", {31'b0, imem_req},    32'h0);
        check_eq("t6_rst_v",   {31'b0, instr_valid}, 32'h0);
        ack_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_restart", imem_addr, 32'h0);
        @(negedge clk);
        check_eq("t6_re_v",  {31'b0, instr_valid}, 32'h1);
        check_eq("t6_re_pc", pc_out,               32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
